// File: rtl/pipe_pkg.sv
// Shared pipeline types for hazard tracking: forward-select codes, the
// per-stage destination record and the saturating Tnew decrement.
package pipe_pkg;

  localparam int SB_REG_AW = 5;
  localparam int SB_TN_W   = 2;

  localparam logic [1:0] FWD_RF = 2'd0;
  localparam logic [1:0] FWD_E  = 2'd1;
  localparam logic [1:0] FWD_M  = 2'd2;
  localparam logic [1:0] FWD_W  = 2'd3;

  localparam logic [SB_REG_AW-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic [SB_REG_AW-1:0] a1;
    logic [SB_REG_AW-1:0] a2;
    logic [SB_REG_AW-1:0] a3;
    logic [SB_TN_W-1:0]   tnew;
  } sb_rec_t;

  function automatic logic [SB_TN_W-1:0] sat_dec(input logic [SB_TN_W-1:0] t);
    return (t == '0) ? '0 : t - SB_TN_W'(1);
  endfunction

endpackage

// File: rtl/sb_stage_reg.sv
// One pipeline-stage record register: loads the upstream record with Tnew
// decremented (saturating at 0), or a bubble; read-address fields can be tied off.
module sb_stage_reg
  import pipe_pkg::*;
#(
  parameter bit KEEP_A1 = 1'b1,
  parameter bit KEEP_A2 = 1'b1
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    bubble,
  input  sb_rec_t rec_in,
  output sb_rec_t rec_out
);

  sb_rec_t rec_reg;
  sb_rec_t rec_next;
  logic [SB_REG_AW-1:0] a1_keep;
  logic [SB_REG_AW-1:0] a2_keep;
  logic unused_in_fields;

  // Later stages never consume rs (and W never consumes rt), so those fields stay zero.
  generate
    if (KEEP_A1) begin : g_a1
      assign a1_keep = rec_in.a1;
    end else begin : g_a1_tie
      assign a1_keep = REG_ZERO;
    end
    if (KEEP_A2) begin : g_a2
      assign a2_keep = rec_in.a2;
    end else begin : g_a2_tie
      assign a2_keep = REG_ZERO;
    end
  endgenerate

  assign unused_in_fields = ^{rec_in.a1, rec_in.a2};

  always_comb begin
    rec_next = '0;
    if (!bubble) begin
      rec_next.a1   = a1_keep;
      rec_next.a2   = a2_keep;
      rec_next.a3   = rec_in.a3;
      rec_next.tnew = sat_dec(rec_in.tnew);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rec_reg <= '0;
    end else begin
      rec_reg <= rec_next;
    end
  end

  assign rec_out = rec_reg;

endmodule

// File: rtl/hazard_scoreboard.sv
// Tracks E/M/W destination records of the 5-stage pipe, raises stall on
// unresolvable RAW hazards and produces the D/E/M forward-mux selects.
module hazard_scoreboard
  import pipe_pkg::*;
#(
  parameter int REG_AW = SB_REG_AW,
  parameter int TN_W   = SB_TN_W,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] d_a1,
  input  logic [REG_AW-1:0] d_a2,
  input  logic [REG_AW-1:0] d_a3,
  input  logic [TN_W-1:0]   d_tuse1,
  input  logic [TN_W-1:0]   d_tuse2,
  input  logic [TN_W-1:0]   d_tnew,
  output logic              stall,
  output logic [1:0]        fwd_d_rs,
  output logic [1:0]        fwd_d_rt,
  output logic [1:0]        fwd_e_rs,
  output logic [1:0]        fwd_e_rt,
  output logic [1:0]        fwd_m_rt,
  output logic [CNT_W-1:0]  stall_cnt
);

  sb_rec_t d_rec;
  sb_rec_t stage_in [3];
  logic    stage_bubble [3];
  sb_rec_t rec_q [3];
  sb_rec_t rec_e;
  sb_rec_t rec_m;
  sb_rec_t rec_w;
  logic [CNT_W-1:0] stall_cnt_reg;
  logic unused_rec_fields;

  assign d_rec = '{a1: d_a1, a2: d_a2, a3: d_a3, tnew: d_tnew};

  // Stage 0 = E, 1 = M, 2 = W; only the D->E load can be turned into a bubble.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_stage
      if (gi == 0) begin : g_src_d
        assign stage_in[gi]     = d_rec;
        assign stage_bubble[gi] = stall;
      end else begin : g_src_prev
        assign stage_in[gi]     = rec_q[gi-1];
        assign stage_bubble[gi] = 1'b0;
      end
      sb_stage_reg #(
        .KEEP_A1 (gi == 0),
        .KEEP_A2 (gi < 2)
      ) u_stage (
        .clk     (clk),
        .reset   (reset),
        .bubble  (stage_bubble[gi]),
        .rec_in  (stage_in[gi]),
        .rec_out (rec_q[gi])
      );
    end
  endgenerate

  assign rec_e = rec_q[0];
  assign rec_m = rec_q[1];
  assign rec_w = rec_q[2];
  assign unused_rec_fields = ^{rec_m.a1, rec_w.a1, rec_w.a2};

  function automatic logic addr_hit(input logic [SB_REG_AW-1:0] a, input sb_rec_t r);
    return (a != REG_ZERO) && (a == r.a3);
  endfunction

  function automatic logic needs_wait(input logic [SB_REG_AW-1:0] a,
                                      input logic [SB_TN_W-1:0] tuse, input sb_rec_t r);
    return addr_hit(a, r) && (tuse < r.tnew);
  endfunction

  // Later assignments override earlier ones, so the nearest ready producer wins.
  function automatic logic [1:0] fwd_sel(input logic [SB_REG_AW-1:0] a,
                                         input logic search_e, input logic search_m,
                                         input sb_rec_t e, input sb_rec_t m, input sb_rec_t w);
    logic [1:0] sel;
    sel = FWD_RF;
    if (addr_hit(a, w) && (w.tnew == '0)) sel = FWD_W;
    if (search_m && addr_hit(a, m) && (m.tnew == '0)) sel = FWD_M;
    if (search_e && addr_hit(a, e) && (e.tnew == '0)) sel = FWD_E;
    return sel;
  endfunction

  assign stall = needs_wait(d_a1, d_tuse1, rec_e) | needs_wait(d_a1, d_tuse1, rec_m)
               | needs_wait(d_a2, d_tuse2, rec_e) | needs_wait(d_a2, d_tuse2, rec_m);

  assign fwd_d_rs = fwd_sel(d_a1,     1'b1, 1'b1, rec_e, rec_m, rec_w);
  assign fwd_d_rt = fwd_sel(d_a2,     1'b1, 1'b1, rec_e, rec_m, rec_w);
  assign fwd_e_rs = fwd_sel(rec_e.a1, 1'b0, 1'b1, rec_e, rec_m, rec_w);
  assign fwd_e_rt = fwd_sel(rec_e.a2, 1'b0, 1'b1, rec_e, rec_m, rec_w);
  assign fwd_m_rt = fwd_sel(rec_m.a2, 1'b0, 1'b0, rec_e, rec_m, rec_w);

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_reg <= '0;
    end else if (stall) begin
      stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
    end
  end

  assign stall_cnt = stall_cnt_reg;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Table-driven directed sequences plus randomized traffic checked against an
// instruction-queue model of the E/M/W pipeline.
module tb_hazard_scoreboard;

  localparam int AW = 5;
  localparam int TW = 2;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] d_a1, d_a2, d_a3;
  logic [TW-1:0] d_tuse1, d_tuse2, d_tnew;
  logic          stall;
  logic [1:0]    fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, fwd_m_rt;
  logic [CW-1:0] stall_cnt;

  always #5 clk = ~clk;

  hazard_scoreboard #(.REG_AW(AW), .TN_W(TW), .CNT_W(CW)) dut (
    .clk       (clk),
    .reset     (reset),
    .d_a1      (d_a1),
    .d_a2      (d_a2),
    .d_a3      (d_a3),
    .d_tuse1   (d_tuse1),
    .d_tuse2   (d_tuse2),
    .d_tnew    (d_tnew),
    .stall     (stall),
    .fwd_d_rs  (fwd_d_rs),
    .fwd_d_rt  (fwd_d_rt),
    .fwd_e_rs  (fwd_e_rs),
    .fwd_e_rt  (fwd_e_rt),
    .fwd_m_rt  (fwd_m_rt),
    .stall_cnt (stall_cnt)
  );

  typedef struct {
    bit rst;
    int a1, a2, a3, t1, t2, tn;
    bit st;
    int fdrs, fdrt, fers, fert, fmrt, cnt;
  } vec_t;

  // In-flight instruction as issued from D; index 0 = E, 1 = M, 2 = W.
  typedef struct {
    bit v;
    int a1, a2, a3, tn;
  } inst_t;

  vec_t        tbl[$];
  inst_t       pipe_q[$];
  int unsigned cnt_model;
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  bit          last_stall;

  function automatic vec_t mk(bit rst, int a1, int a2, int a3, int t1, int t2, int tn,
                              bit st, int fdrs, int fdrt, int fers, int fert, int fmrt, int cnt);
    vec_t x;
    x.rst = rst; x.a1 = a1; x.a2 = a2; x.a3 = a3; x.t1 = t1; x.t2 = t2; x.tn = tn;
    x.st = st; x.fdrs = fdrs; x.fdrt = fdrt; x.fers = fers; x.fert = fert;
    x.fmrt = fmrt; x.cnt = cnt;
    return x;
  endfunction

  function automatic vec_t nop(int fers, int fert, int fmrt, int cnt);
    return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, fers, fert, fmrt, cnt);
  endfunction

  // Remaining cycles until the producer at pipeline position idx has its result.
  function automatic int tnew_at(int idx);
    int age;
    age = idx + 1;
    return (pipe_q[idx].tn > age) ? pipe_q[idx].tn - age : 0;
  endfunction

  function automatic bit writes(int idx, int a);
    return pipe_q[idx].v && (a != 0) && (pipe_q[idx].a3 == a);
  endfunction

  function automatic int fwd_from(int first, int a);
    int sel;
    bit found;
    sel = 0;
    found = 0;
    for (int i = first; i < 3; i++) begin
      if (!found && writes(i, a) && tnew_at(i) == 0) begin
        sel = i + 1;
        found = 1;
      end
    end
    return sel;
  endfunction

  function automatic bit must_wait(int a, int tuse);
    bit w;
    w = 0;
    for (int i = 0; i < 2; i++)
      if (writes(i, a) && tuse < tnew_at(i)) w = 1;
    return w;
  endfunction

  function automatic inst_t bubble_inst();
    inst_t b;
    b.v = 0; b.a1 = 0; b.a2 = 0; b.a3 = 0; b.tn = 0;
    return b;
  endfunction

  task automatic model_clear();
    pipe_q.delete();
    for (int i = 0; i < 3; i++) pipe_q.push_back(bubble_inst());
    cnt_model = 0;
  endtask

  task automatic chk(string name, int unsigned act, int unsigned exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL cycle %0d %s: got %0d, expected %0d", cyc, name, act, exp);
    end
  endtask

  task automatic do_cycle(input vec_t x, input bit from_tbl);
    vec_t  e;
    inst_t ni;
    reset   = x.rst;
    d_a1    = x.a1[AW-1:0];
    d_a2    = x.a2[AW-1:0];
    d_a3    = x.a3[AW-1:0];
    d_tuse1 = x.t1[TW-1:0];
    d_tuse2 = x.t2[TW-1:0];
    d_tnew  = x.tn[TW-1:0];
    @(negedge clk);
    e.st   = must_wait(x.a1, x.t1) || must_wait(x.a2, x.t2);
    e.fdrs = fwd_from(0, x.a1);
    e.fdrt = fwd_from(0, x.a2);
    e.fers = fwd_from(1, pipe_q[0].a1);
    e.fert = fwd_from(1, pipe_q[0].a2);
    e.fmrt = fwd_from(2, pipe_q[1].a2);
    e.cnt  = int'(cnt_model);
    last_stall = e.st;
    if (from_tbl) begin
      chk("stall", 32'(stall), 32'(x.st));
      chk("fwd_d_rs", 32'(fwd_d_rs), x.fdrs);
      chk("fwd_d_rt", 32'(fwd_d_rt), x.fdrt);
      chk("fwd_e_rs", 32'(fwd_e_rs), x.fers);
      chk("fwd_e_rt", 32'(fwd_e_rt), x.fert);
      chk("fwd_m_rt", 32'(fwd_m_rt), x.fmrt);
      chk("stall_cnt", stall_cnt, x.cnt);
    end else begin
      chk("rnd stall", 32'(stall), 32'(e.st));
      chk("rnd fwd_d_rs", 32'(fwd_d_rs), e.fdrs);
      chk("rnd fwd_d_rt", 32'(fwd_d_rt), e.fdrt);
      chk("rnd fwd_e_rs", 32'(fwd_e_rs), e.fers);
      chk("rnd fwd_e_rt", 32'(fwd_e_rt), e.fert);
      chk("rnd fwd_m_rt", 32'(fwd_m_rt), e.fmrt);
      chk("rnd stall_cnt", stall_cnt, cnt_model);
    end
    @(posedge clk);
    if (x.rst) begin
      model_clear();
    end else begin
      if (e.st) begin
        cnt_model++;
        ni = bubble_inst();
      end else begin
        ni.v = 1; ni.a1 = x.a1; ni.a2 = x.a2; ni.a3 = x.a3; ni.tn = x.tn;
      end
      pipe_q.push_front(ni);
      void'(pipe_q.pop_back());
    end
    cyc++;
    #1;
  endtask

  initial begin
    vec_t r;
    reset = 1'b1;
    d_a1 = '0; d_a2 = '0; d_a3 = '0; d_tuse1 = '0; d_tuse2 = '0; d_tnew = '0;
    model_clear();
    last_stall = 0;

    //            rst a1 a2 a3 t1 t2 tn   st drs drt ers ert mrt cnt
    tbl.push_back(nop(0, 0, 0, 0));                                        // reset state
    tbl.push_back(mk(0, 29, 0,  8, 1, 3, 3,  0, 0, 0, 0, 0, 0, 0));        // lw $8
    tbl.push_back(mk(0,  8, 8,  9, 1, 1, 2,  1, 0, 0, 0, 0, 0, 0));        // addu $9,$8,$8
    tbl.push_back(mk(0,  8, 8,  9, 1, 1, 2,  0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(nop(3, 3, 0, 1));
    tbl.push_back(nop(0, 0, 0, 1));
    tbl.push_back(nop(0, 0, 0, 1));
    tbl.push_back(mk(0,  4, 5,  8, 1, 1, 2,  0, 0, 0, 0, 0, 0, 1));        // addu $8
    tbl.push_back(mk(0,  8, 0,  0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 1));        // beq $8,$0
    tbl.push_back(mk(0,  8, 0,  0, 0, 0, 0,  0, 2, 0, 0, 0, 0, 2));
    tbl.push_back(nop(3, 0, 0, 2));
    tbl.push_back(nop(0, 0, 0, 2));
    tbl.push_back(nop(0, 0, 0, 2));
    tbl.push_back(mk(0,  0, 0, 31, 0, 0, 1,  0, 0, 0, 0, 0, 0, 2));        // jal
    tbl.push_back(mk(0, 31, 0,  0, 0, 0, 0,  0, 1, 0, 0, 0, 0, 2));        // jr $31
    tbl.push_back(nop(2, 0, 0, 2));
    tbl.push_back(nop(0, 0, 0, 2));
    tbl.push_back(nop(0, 0, 0, 2));
    tbl.push_back(mk(0, 29, 0,  0, 1, 3, 3,  0, 0, 0, 0, 0, 0, 2));        // lw $0
    tbl.push_back(mk(0,  0, 0,  0, 0, 0, 2,  0, 0, 0, 0, 0, 0, 2));        // addu $0
    tbl.push_back(mk(0,  0, 0,  0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 2));        // beq $0,$0
    tbl.push_back(mk(0,  0, 0,  0, 1, 2, 0,  0, 0, 0, 0, 0, 0, 2));        // sw $0,0($0)
    tbl.push_back(nop(0, 0, 0, 2));
    tbl.push_back(nop(0, 0, 0, 2));
    tbl.push_back(nop(0, 0, 0, 2));
    tbl.push_back(mk(0, 29, 0,  8, 1, 3, 3,  0, 0, 0, 0, 0, 0, 2));        // lw $8
    tbl.push_back(mk(0,  4, 0,  8, 1, 3, 2,  0, 0, 0, 0, 0, 0, 2));        // ori $8
    tbl.push_back(mk(0,  8, 8,  0, 1, 2, 0,  0, 0, 0, 0, 0, 0, 2));        // sw $8,0($8)
    tbl.push_back(nop(2, 2, 0, 2));
    tbl.push_back(nop(0, 0, 3, 2));
    tbl.push_back(nop(0, 0, 0, 2));
    tbl.push_back(mk(0, 29, 0,  8, 1, 3, 3,  0, 0, 0, 0, 0, 0, 2));        // lw $8
    tbl.push_back(mk(1,  8, 0,  0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 2));        // beq + reset
    tbl.push_back(mk(0,  1, 2,  3, 1, 1, 2,  0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0,  4, 5,  6, 1, 1, 2,  0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0,  7, 9, 10, 1, 1, 2,  0, 0, 0, 0, 0, 0, 0));

    repeat (2) @(posedge clk);
    #1;
    foreach (tbl[i]) do_cycle(tbl[i], 1'b1);

    r = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    do_cycle(r, 1'b0);
    for (int n = 0; n < 800; n++) begin
      if (!(last_stall && $urandom_range(0, 3) != 0)) begin
        r.a1 = int'($urandom_range(0, 3));
        r.a2 = int'($urandom_range(0, 3));
        r.a3 = int'($urandom_range(0, 3));
        r.t1 = int'($urandom_range(0, 3));
        r.t2 = int'($urandom_range(0, 3));
        r.tn = int'($urandom_range(0, 3));
      end
      r.rst = ($urandom_range(0, 63) == 0);
      do_cycle(r, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
